// File: rtl/mux_nt1_stream.sv
// N-to-1 registered stream multiplexer with valid/ready on every port.
// Channel choice is direct (external select) or round-robin among valid channels.
module mux_nt1_stream #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] I,
    input  logic [N-1:0]       I_valid,
    output logic [N-1:0]       I_ready,
    input  logic [SELW-1:0]    s,
    input  logic               mode,
    output logic [WIDTH-1:0]   o,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [SELW-1:0]    grant
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  sel;
    logic [SELW-1:0]  rr_sel;
    logic [SELW-1:0]  sel_inc;
    logic             rr_hit;
    logic             direct_hit;
    logic             hit;
    logic             load_en;
    logic             accept;
    logic [WIDTH-1:0] sel_data;

    assign load_en = !o_valid || o_ready;

    // Out-of-range selects never match a channel, so they yield no candidate.
    always_comb begin : direct_choice
        direct_hit = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(s) == k && I_valid[k]) begin
                direct_hit = 1'b1;
            end
        end
    end

    // Two passes (ptr..N-1, then 0..ptr-1) give the circular scan wrapping at N.
    always_comb begin : rr_choice
        rr_hit = 1'b0;
        rr_sel = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!rr_hit && I_valid[k] && k >= 32'(ptr)) begin
                rr_hit = 1'b1;
                rr_sel = k[SELW-1:0];
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            if (!rr_hit && I_valid[k] && k < 32'(ptr)) begin
                rr_hit = 1'b1;
                rr_sel = k[SELW-1:0];
            end
        end
    end

    assign sel     = mode ? rr_sel : s;
    assign hit     = mode ? rr_hit : direct_hit;
    assign accept  = hit && load_en && !rst;
    assign sel_inc = (32'(sel) == N - 1) ? '0 : sel + SELW'(1);

    always_comb begin : route
        I_ready  = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == k[SELW-1:0]) begin
                I_ready[k] = accept;
                sel_data   = I[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o       <= '0;
            o_valid <= 1'b0;
            grant   <= '0;
            ptr     <= '0;
        end else if (accept) begin
            o       <= sel_data;
            grant   <= sel;
            o_valid <= 1'b1;
            if (mode) begin
                ptr <= sel_inc;
            end
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nt1_stream.sv
// Bench for mux_nt1_stream: a 4-channel and a 3-channel instance share stimulus
// and are compared each cycle against a behavioural model plus directed constants.
module tb_mux_nt1_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic         o_ready;
    logic [1:0]   s;
    logic [3:0]   vld;
    logic [63:0]  din [4];
    logic [255:0] i4;
    logic [191:0] i3;
    logic [3:0]   rdy4;
    logic [2:0]   rdy3;
    logic [63:0]  o4, o3;
    logic         ov4, ov3;
    logic [1:0]   g4, g3;

    always #5 clk = ~clk;

    assign i4 = {din[3], din[2], din[1], din[0]};
    assign i3 = {din[2], din[1], din[0]};

    mux_nt1_stream #(.WIDTH(64), .N(4), .SELW(2)) dut4 (
        .clk(clk), .rst(rst), .I(i4), .I_valid(vld), .I_ready(rdy4),
        .s(s), .mode(mode), .o(o4), .o_valid(ov4), .o_ready(o_ready), .grant(g4)
    );

    mux_nt1_stream #(.WIDTH(64), .N(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .I(i3), .I_valid(vld[2:0]), .I_ready(rdy3),
        .s(s), .mode(mode), .o(o3), .o_valid(ov3), .o_ready(o_ready), .grant(g3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model state per instance: index 0 is N=4, index 1 is N=3.
    logic [63:0] mo [2];
    bit          mv [2];
    int          mg [2];
    int          mp [2];
    int          exp_rdy [2];

    function automatic int choose(input int n, input int p);
        if (!mode) begin
            return (int'(s) < n && vld[s]) ? int'(s) : -1;
        end
        for (int d = 0; d < n; d++) begin
            int k = (p + d) % n;
            if (vld[k[1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic model_cycle();
        for (int u = 0; u < 2; u++) begin
            int  n  = (u == 0) ? 4 : 3;
            int  k  = choose(n, mp[u]);
            bit  ld = !mv[u] || o_ready;
            bit  acc = !rst && ld && (k >= 0);
            exp_rdy[u] = acc ? (1 << k) : 0;
            if (rst) begin
                mo[u] = '0; mv[u] = 0; mg[u] = 0; mp[u] = 0;
            end else if (acc) begin
                mo[u] = din[k[1:0]];
                mg[u] = k;
                mv[u] = 1;
                if (mode) mp[u] = (k + 1) % n;
            end else if (o_ready) begin
                mv[u] = 0;
            end
        end
    endtask

    task automatic step();
        #1;
        model_cycle();
        check("rdy4", 64'(rdy4), 64'(exp_rdy[0]));
        check("rdy3", 64'(rdy3), 64'(exp_rdy[1]));
        @(posedge clk);
        @(negedge clk);
        check("o4", o4, mo[0]);
        check("ov4", 64'(ov4), 64'(mv[0]));
        check("g4", 64'(g4), 64'(mg[0]));
        check("o3", o3, mo[1]);
        check("ov3", 64'(ov3), 64'(mv[1]));
        check("g3", 64'(g3), 64'(mg[1]));
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            mo[u] = '0; mv[u] = 0; mg[u] = 0; mp[u] = 0; exp_rdy[u] = 0;
        end
        for (int k = 0; k < 4; k++) din[k] = 64'(k) * 64'h0101_0101_0101_0101;
        rst = 1'b1; mode = 1'b0; s = 2'd0; vld = 4'hF; o_ready = 1'b1;

        // Reset with every channel offering a word
        step();
        step();
        check("rst_o", o4, 64'd0);
        check("rst_ov", 64'(ov4), 64'd0);
        check("rst_g", 64'(g4), 64'd0);
        check("rst_rdy", 64'(rdy4), 64'd0);

        // Direct select
        rst = 1'b0;
        din[0] = 64'h5555_5555_5555_5555;
        din[1] = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        check("dir_o0", o4, 64'h5555_5555_5555_5555);
        check("dir_g0", 64'(g4), 64'd0);
        s = 2'd1;
        step();
        check("dir_o1", o4, 64'hAAAA_AAAA_AAAA_AAAA);
        check("dir_g1", 64'(g4), 64'd1);

        // Round-robin fairness
        mode = 1'b1;
        for (int k = 0; k < 4; k++) din[k] = 64'(k + 1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_g", 64'(g4), 64'(i % 4));
            check("rr_o", o4, 64'(i % 4 + 1));
        end

        // Skip and wrap: park ptr at 2 via channel 1, then channels 3 and 1 alternate
        vld = 4'b0010;
        step();
        check("park_g", 64'(g4), 64'd1);
        vld = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("skip_g", 64'(g4), (i % 2 == 0) ? 64'd3 : 64'd1);
        end

        // Backpressure
        mode = 1'b0; s = 2'd0; vld = 4'hF;
        din[0] = 64'h5555_5555_5555_5555;
        step();
        o_ready = 1'b0;
        din[0] = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_o", o4, 64'h5555_5555_5555_5555);
            check("bp_g", 64'(g4), 64'd0);
            check("bp_rdy", 64'(rdy4), 64'd0);
        end
        o_ready = 1'b1;
        step();
        check("bp_new_o", o4, 64'h1234_5678_9ABC_DEF0);
        check("bp_new_ov", 64'(ov4), 64'd1);

        // Out-of-range select on the 3-channel instance
        s = 2'd3;
        step();
        check("oor_rdy", 64'(rdy3), 64'd0);
        check("oor_ov", 64'(ov3), 64'd0);

        // Reset during a stall
        s = 2'd0;
        step();
        check("mr_load", 64'(ov3), 64'd1);
        o_ready = 1'b0;
        step();
        check("mr_stall", 64'(ov3), 64'd1);
        rst = 1'b1;
        step();
        check("mr_rdy", 64'(rdy3), 64'd0);
        check("mr_ov", 64'(ov3), 64'd0);
        check("mr_o", o3, 64'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) din[k] = {$urandom, $urandom};
            vld     = 4'($urandom);
            s       = 2'($urandom);
            mode    = ($urandom_range(0, 3) != 0);
            o_ready = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nt1_stream.md
# mux_nt1_stream

Parametrised N-to-1 registered stream multiplexer, successor to the fixed 64-bit two-input mux in the element library. It selects one of N input channels of WIDTH bits and delivers the word through a single output register with valid/ready handshakes on every port. Selection is either direct (external select) or round-robin among valid channels. It sits between datapath producers (register file read ports, ALU/memory result buses) and a single consumer stage.

## Interface
- WIDTH, 64, data width per channel
- N, 4, number of input channels (2..16)
- SELW, 2, select/grant width; must satisfy 2^SELW >= N
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- I  in  N*WIDTH  flattened channel data; channel k at bits [k*WIDTH +: WIDTH]
- I_valid  in  N  channel k offers a word
- I_ready  out  N  channel k word accepted this cycle (combinational)
- s  in  SELW  direct select, used when mode=0
- mode  in  1  0 = direct select, 1 = round-robin
- o  out  WIDTH  registered output word
- o_valid  out  1  o holds an unconsumed word
- o_ready  in  1  consumer takes o this cycle
- grant  out  SELW  registered index of the channel that supplied o

## Operation
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: o=0, o_valid=0, grant=0, round-robin pointer ptr=0.
- Load condition: load_en = !o_valid | o_ready (register empty or drained this cycle).
- Channel choice (combinational, sel):
  - mode=0: sel=s. Candidate only if s<N and I_valid[s]=1; if s>=N, no candidate.
  - mode=1: first k with I_valid[k]=1 scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap at N, not at 2^SELW). No valid channel: no candidate.
- Accept: I_ready[k]=1 iff a candidate exists, k==sel, and load_en. At most one I_ready bit high per cycle. I_ready[k] must not depend on I_ready of other channels.
- On accept: o<=I[sel], grant<=sel, o_valid<=1. In mode=1 only: ptr<=(sel==N-1)?0:sel+1. In mode=0 ptr unchanged.
- No accept and o_ready=1 with o_valid=1: o_valid<=0; o and grant hold last values.
- Stall (o_valid=1, o_ready=0): o, grant, o_valid held stable; all I_ready=0.
- Simultaneous drain and accept: new word replaces old in same edge; o_valid stays 1.
- Mode change: takes effect on the next choice computation; no flush, no loss of held output.
- rst asserted mid-transfer: held word discarded, o_valid=0 next cycle, I_ready=0 during rst cycle.

## Timing
- Latency: accept at edge t -> o/o_valid visible after edge t (1 cycle).
- Throughput: one word per cycle while o_ready=1 and a candidate exists.
- I_ready is combinational from I_valid, s, mode, ptr, o_valid, o_ready; no combinational path from I data to any output.
- ptr updates only on an accepted round-robin transfer.

## Test plan
- Reset: rst=1 for 2 cycles with all I_valid=1 -> o=0, o_valid=0, grant=0, I_ready=0; release -> first accept next cycle.
- Direct select: mode=0, N=4, I0=64'h5555555555555555, I1=64'hAAAAAAAAAAAAAAAA, all valid, o_ready=1, s=0 then s=1 -> o=5555..., grant=0; then o=AAAA..., grant=1, one cycle after each select.
- Round-robin fairness: mode=1, all 4 valid, o_ready=1 for 8 cycles, I[k]=k+1 -> grant sequence 0,1,2,3,0,1,2,3; o=1,2,3,4,1,2,3,4; exactly one I_ready bit high each cycle.
- Round-robin skip and wrap: mode=1, only I_valid[3] and I_valid[1], ptr=2 -> grants 3,1,3,1.
- Backpressure: o_valid=1 with o=5555..., o_ready=0 for 5 cycles -> o, grant stable, all I_ready=0; o_ready=1 -> new word loaded same edge, o_valid stays 1.
- Out-of-range select and mid-reset: N=3, mode=0, s=3 -> no I_ready, o_valid falls after drain; rst asserted during stall -> o_valid=0, o=0 next cycle.
